// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data block-memory arbiter.
// The round-robin grant option is selected by macro MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned BLOCK_W_DEF = 128;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIRead  = 2'd1,
    StDWrite = 2'd2,
    StDRead  = 2'd3
  } state_e;

  typedef enum logic {
    GrantInstr = 1'b0,
    GrantData  = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant selection between instruction and data requesters.
// MEM_ARB_ROUND_ROBIN_EN: contested grants go to the side not granted last.
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic   i_instr_req,
  input  logic   i_data_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  grant_e i_last_grant,
`endif
  output logic   o_grant_valid,
  output grant_e o_grant
);

  always_comb begin
    o_grant_valid = i_instr_req | i_data_req;
    o_grant       = GrantInstr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_instr_req && i_data_req) begin
      o_grant = (i_last_grant == GrantData) ? GrantInstr : GrantData;
    end else if (i_data_req) begin
      o_grant = GrantData;
    end
`else
    if (i_data_req) begin
      o_grant = GrantData;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared block memory between instruction refills and data write-back/refill.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration; default is data-first fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned BLOCK_W = BLOCK_W_DEF
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_read_data,
  output logic               i_read_valid,

  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_read_address,
  input  logic [ADDR_W-1:0]  d_write_address,
  input  logic [BLOCK_W-1:0] d_write_data,
  output logic [BLOCK_W-1:0] d_read_data,
  output logic               d_read_valid,
  output logic               d_write_done,

  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_read_address,
  output logic [ADDR_W-1:0]  mem_write_address,
  output logic [BLOCK_W-1:0] mem_write_data,
  input  logic [BLOCK_W-1:0] mem_read_data,
  input  logic               mem_read_valid,
  input  logic               mem_write_done,

  output logic               busy
);

  state_e r_state, w_state_next;
  logic   w_data_req;
  logic   w_grant_valid;
  grant_e w_grant;

  assign w_data_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_e r_last_grant;

  // Resets to "data last" so the first contested grant favours the instruction side.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_grant <= GrantData;
    end else if (r_state == StIdle && w_grant_valid) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  mem_arb_select u_select (
    .i_instr_req   (i_read),
    .i_data_req    (w_data_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .i_last_grant  (r_last_grant),
`endif
    .o_grant_valid (w_grant_valid),
    .o_grant       (w_grant)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Write-back chains straight into its refill so the instruction side cannot slip in between.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_valid) begin
          if (w_grant == GrantData) begin
            w_state_next = d_write ? StDWrite : StDRead;
          end else begin
            w_state_next = StIRead;
          end
        end
      end
      StIRead:  if (mem_read_valid) w_state_next = StIdle;
      StDWrite: if (mem_write_done) w_state_next = d_read ? StDRead : StIdle;
      StDRead:  if (mem_read_valid) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy              = (r_state != StIdle);
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    i_read_valid      = 1'b0;
    i_read_data       = '0;
    d_read_valid      = 1'b0;
    d_read_data       = '0;
    d_write_done      = 1'b0;
    unique case (r_state)
      StIRead: begin
        mem_read         = 1'b1;
        mem_read_address = i_address;
        if (mem_read_valid) begin
          i_read_valid = 1'b1;
          i_read_data  = mem_read_data;
        end
      end
      StDWrite: begin
        mem_write         = 1'b1;
        mem_write_address = d_write_address;
        mem_write_data    = d_write_data;
        d_write_done      = mem_write_done;
      end
      StDRead: begin
        mem_read         = 1'b1;
        mem_read_address = d_read_address;
        if (mem_read_valid) begin
          d_read_valid = 1'b1;
          d_read_data  = mem_read_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a transaction-level ownership model.
// Honours MEM_ARB_ROUND_ROBIN_EN to pick the expected arbitration rule.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int BW = 128;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_DW   = 2;
  localparam int OWN_DR   = 3;

  logic          clock;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [BW-1:0] i_read_data;
  logic          i_read_valid;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_read_address;
  logic [AW-1:0] d_write_address;
  logic [BW-1:0] d_write_data;
  logic [BW-1:0] d_read_data;
  logic          d_read_valid;
  logic          d_write_done;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_read_address;
  logic [AW-1:0] mem_write_address;
  logic [BW-1:0] mem_write_data;
  logic [BW-1:0] mem_read_data;
  logic          mem_read_valid;
  logic          mem_write_done;
  logic          busy;

  logic auto_rd, auto_wd, spur_rd;
  assign mem_read_valid = auto_rd | spur_rd;
  assign mem_write_done = auto_wd;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clock             (clock),
    .reset             (reset),
    .i_read            (i_read),
    .i_address         (i_address),
    .i_read_data       (i_read_data),
    .i_read_valid      (i_read_valid),
    .d_read            (d_read),
    .d_write           (d_write),
    .d_read_address    (d_read_address),
    .d_write_address   (d_write_address),
    .d_write_data      (d_write_data),
    .d_read_data       (d_read_data),
    .d_read_valid      (d_read_valid),
    .d_write_done      (d_write_done),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .mem_read_valid    (mem_read_valid),
    .mem_write_done    (mem_write_done),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: who owns the memory this cycle and who was granted last.
  int   m_owner = OWN_NONE;
  int   m_next  = OWN_NONE;
  logic m_last_data = 1'b1;
  logic chk_en = 1'b0;

  // Memory responder and event log.
  int          lat = 1;
  int          cnt = 0;
  logic [63:0] ev_log;
  int          n_iv, n_dv, n_wd, n_busy, cyc, t_iv, t_dv, t_wd;
  logic [BW-1:0] last_ird;
  logic        seen_iv, seen_dv, seen_wd;

  function automatic logic [BW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h0000_0040) return 128'hDEAD_C0DE_0123_4567_89AB_CDEF_F00D_BEEF;
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0FF_EE00};
  endfunction

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic          e_iv, e_dv, e_wd;
    logic [AW-1:0] e_mra, e_mwa;
    logic          data_req;
    m_owner = m_next;
    e_iv  = (m_owner == OWN_I)  && mem_read_valid;
    e_dv  = (m_owner == OWN_DR) && mem_read_valid;
    e_wd  = (m_owner == OWN_DW) && mem_write_done;
    e_mra = (m_owner == OWN_I) ? i_address : (m_owner == OWN_DR) ? d_read_address : '0;
    e_mwa = (m_owner == OWN_DW) ? d_write_address : '0;
    if (chk_en) begin
      chk("busy", busy, m_owner != OWN_NONE);
      chk("mem_read", mem_read, (m_owner == OWN_I) || (m_owner == OWN_DR));
      chk("mem_write", mem_write, m_owner == OWN_DW);
      chk("rd_wr_excl", mem_read & mem_write, 1'b0);
      chk("mem_read_address", mem_read_address, e_mra);
      chk("mem_write_address", mem_write_address, e_mwa);
      chk("mem_write_data", mem_write_data, (m_owner == OWN_DW) ? d_write_data : '0);
      chk("i_read_valid", i_read_valid, e_iv);
      chk("i_read_data", i_read_data, e_iv ? mem_read_data : '0);
      chk("d_read_valid", d_read_valid, e_dv);
      chk("d_read_data", d_read_data, e_dv ? mem_read_data : '0);
      chk("d_write_done", d_write_done, e_wd);
    end
    data_req = d_read | d_write;
    m_next = m_owner;
    if (!reset) begin
      m_next = OWN_NONE;
      m_last_data = 1'b1;
    end else begin
      case (m_owner)
        OWN_NONE: begin
          if (data_req && i_read) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_next = m_last_data ? OWN_I : (d_write ? OWN_DW : OWN_DR);
`else
            m_next = d_write ? OWN_DW : OWN_DR;
`endif
          end else if (data_req) begin
            m_next = d_write ? OWN_DW : OWN_DR;
          end else if (i_read) begin
            m_next = OWN_I;
          end
          if (m_next != OWN_NONE) m_last_data = (m_next != OWN_I);
        end
        OWN_I:  if (mem_read_valid) m_next = OWN_NONE;
        OWN_DW: if (mem_write_done) m_next = d_read ? OWN_DR : OWN_NONE;
        OWN_DR: if (mem_read_valid) m_next = OWN_NONE;
        default: m_next = OWN_NONE;
      endcase
    end
  endtask

  task automatic clear_log();
    ev_log = '0;
    n_iv = 0; n_dv = 0; n_wd = 0; n_busy = 0;
    cyc = 0; t_iv = -1; t_dv = -1; t_wd = -1;
  endtask

  // One clock: check at negedge, log events, then after the edge retire requests and run memory.
  task automatic step();
    @(negedge clock);
    model_check();
    seen_iv = i_read_valid;
    seen_dv = d_read_valid;
    seen_wd = d_write_done;
    if (i_read_valid) begin ev_log = {ev_log[59:0], 4'h1}; n_iv++; t_iv = cyc; last_ird = i_read_data; end
    if (d_read_valid) begin ev_log = {ev_log[59:0], 4'h2}; n_dv++; t_dv = cyc; end
    if (d_write_done) begin ev_log = {ev_log[59:0], 4'h3}; n_wd++; t_wd = cyc; end
    if (busy === 1'b1) n_busy++;
    cyc++;
    @(posedge clock);
    #1;
    if (seen_iv) i_read = 1'b0;
    if (seen_dv) d_read = 1'b0;
    if (seen_wd) d_write = 1'b0;
    spur_rd = 1'b0;
    auto_rd = 1'b0;
    auto_wd = 1'b0;
    mem_read_data = '0;
    if (mem_read || mem_write) begin
      if (cnt == lat) begin
        auto_rd = mem_read;
        auto_wd = mem_write;
        if (mem_read) mem_read_data = mem_val(mem_read_address);
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      step();
      if (!i_read && !d_read && !d_write && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", done, 1'b1);
    step();
  endtask

  initial begin
    reset = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0;
    d_read_address = '0; d_write_address = '0; d_write_data = '0;
    auto_rd = 1'b0; auto_wd = 1'b0; spur_rd = 1'b0; mem_read_data = '0;
    last_ird = '0;
    clear_log();
    repeat (3) step();
    chk_en = 1'b1;
    reset = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);
    step();

    // Write-back then refill, back to back.
    lat = 2; clear_log();
    d_write = 1'b1; d_read = 1'b1;
    d_write_address = 32'h100; d_read_address = 32'h200;
    d_write_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    run_until_idle(40);
    chk("wb_order", ev_log, 64'h32);
    chk("wb_busy_cycles", n_busy, 6);
    chk("wb_no_gap", t_dv - t_wd, 3);

    // Single instruction refill, 3-cycle memory latency.
    lat = 3; clear_log();
    i_read = 1'b1; i_address = 32'h40;
    run_until_idle(40);
    chk("ird_pulses", n_iv, 1);
    chk("ird_data", last_ird, 128'hDEAD_C0DE_0123_4567_89AB_CDEF_F00D_BEEF);
    chk("ird_busy_cycles", n_busy, 4);

    // Simultaneous requests, twice.
    lat = 1; clear_log();
    for (int r = 0; r < 2; r++) begin
      i_read = 1'b1; i_address = 32'h80 + 32'(r * 4);
      d_read = 1'b1; d_read_address = 32'h300 + 32'(r * 4);
      run_until_idle(40);
    end
    chk("contest_order", ev_log, 64'h2121);

    // Instruction request arriving inside a write-back/refill chain.
    lat = 2; clear_log();
    d_write = 1'b1; d_read = 1'b1;
    d_write_address = 32'h500; d_read_address = 32'h600;
    d_write_data = 128'hA5A5_0000_FFFF_1234_0000_5678_9ABC_DEF0;
    step(); step();
    i_read = 1'b1; i_address = 32'hC0;
    run_until_idle(40);
    chk("chain_order", ev_log, 64'h321);
    chk("chain_i_after_d", t_iv > t_dv, 1'b1);

    // Requester withdraws mid-operation; completion still forwarded.
    lat = 3; clear_log();
    i_read = 1'b1; i_address = 32'h44;
    step(); step();
    i_read = 1'b0;
    run_until_idle(40);
    chk("withdraw_pulses", n_iv, 1);

    // Spurious memory completion while idle.
    clear_log();
    step();
    spur_rd = 1'b1; mem_read_data = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    step(); step();
    chk("spurious_log", ev_log, 64'h0);
    chk("spurious_busy", n_busy, 0);

    // Reset in the middle of an instruction refill, then a late completion.
    lat = 5; clear_log();
    i_read = 1'b1; i_address = 32'h40;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1; i_read = 1'b0;
    spur_rd = 1'b1; mem_read_data = mem_val(32'h40);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_mem_read", mem_read, 1'b0);
    step(); step();
    chk("rst_mid_no_valid", n_iv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width on all ports.
REQ-002 Parameter BLOCK_W, default 128, memory block width.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-005 i_read  input  1  instruction-side block read request; held high until i_read_valid.
REQ-006 i_address  input  ADDR_W  instruction-side read address.
REQ-007 i_read_data  output  BLOCK_W  block returned to instruction side.
REQ-008 i_read_valid  output  1  one-cycle pulse: i_read_data valid, request complete.
REQ-009 d_read  input  1  data-side refill request; held high until d_read_valid.
REQ-010 d_write  input  1  data-side write-back request; held high until d_write_done.
REQ-011 d_read_address, d_write_address  input  ADDR_W each  data-side read and write addresses.
REQ-012 d_write_data  input  BLOCK_W  dirty block to write back.
REQ-013 d_read_data  output  BLOCK_W  block returned to data side.
REQ-014 d_read_valid, d_write_done  output  1 each  one-cycle completion pulses to data side.
REQ-015 mem_read, mem_write  output  1 each  commands to the shared block memory; never high together.
REQ-016 mem_read_address, mem_write_address  output  ADDR_W each  memory addresses.
REQ-017 mem_write_data  output  BLOCK_W  block to write.
REQ-018 mem_read_data  input  BLOCK_W; mem_read_valid, mem_write_done  input  1 each  memory completion pulses.
REQ-019 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-020 FSM states: IDLE, I_READ, D_WRITE, D_READ; state register only, all memory outputs decoded from registered state.
REQ-021 IDLE: no request -> stay; otherwise arbitrate per REQ-027 and enter the granted state next cycle.
REQ-022 Data grant with d_write high -> D_WRITE; with only d_read high -> D_READ.
REQ-023 D_WRITE: mem_write=1, mem_write_address=d_write_address, mem_write_data=d_write_data; on mem_write_done -> pulse d_write_done the same cycle; go to D_READ if d_read is high, else IDLE.
REQ-024 D_READ: mem_read=1, mem_read_address=d_read_address; on mem_read_valid -> d_read_valid pulse the same cycle, d_read_data=mem_read_data, -> IDLE.
REQ-025 I_READ: mem_read=1, mem_read_address=i_address; on mem_read_valid -> i_read_valid pulse the same cycle, i_read_data=mem_read_data, -> IDLE.
REQ-026 Write-back plus refill is atomic: instruction side never granted between D_WRITE and its D_READ.
REQ-027 Default arbitration: fixed priority, data side over instruction side.
REQ-028 Completion pulses are forwarded only to the granted requester; the ungranted side's valid/done stays 0.
REQ-029 Requester deasserting mid-operation: memory operation is not aborted; FSM waits for completion, forwards the pulse, then returns to IDLE.
REQ-030 Minimum one IDLE cycle between grants except the D_WRITE->D_READ chain; overhead per grant is 1 cycle plus memory latency.
REQ-031 Memory completion pulses in IDLE are ignored.

Reset
REQ-032 reset low -> state=IDLE, round-robin pointer=instruction-favoured, all outputs 0 in the following cycle, including mid-operation; in-flight memory completion is dropped.

Configuration
REQ-033 Macro MEM_ARB_ROUND_ROBIN_EN defined: when both sides request in IDLE, grant the side not granted last; a 1-bit last-grant register updates on each grant.
REQ-034 Macro undefined: fixed priority per REQ-027; no last-grant register exists.

Structure
REQ-035 Package mem_arb_pkg holds the state enum, ADDR_W/BLOCK_W default constants, and grant-side encoding.
REQ-036 One sub-module, mem_arb_select: combinational grant selection (fixed or round-robin) from requests and last-grant bit.

Verification
REQ-037 i_read=1, i_address=0x0000_0040, memory valid after 3 cycles with 0xDEAD..BEEF -> i_read_valid single pulse with that data; busy high exactly 4 cycles.
REQ-038 d_write=1 and d_read=1 (write 0x100, read 0x200) -> mem_write then mem_read, d_write_done then d_read_valid, no IDLE cycle between.
REQ-039 i_read and d_read asserted in same cycle, macro undefined -> data served first, instruction second; macro defined, twice in a row -> grants alternate D, I, D, I.
REQ-040 i_read raised during D_WRITE/D_READ chain -> no I_READ grant until after d_read_valid.
REQ-041 reset low during I_READ, then mem_read_valid -> no i_read_valid, all outputs 0, state IDLE.
REQ-042 Spurious mem_read_valid in IDLE -> no completion pulse on either side.
